// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces two raw coin sensors into
// one-cycle coin codes, reject pulses, a busy flag and a saturating total.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned GAP      = 8,
  parameter int unsigned TOTAL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sense_a,
  input  logic               sense_b,
  input  logic               accept_en,
  output logic [1:0]         coin,
  output logic               reject,
  output logic               busy,
  output logic [TOTAL_W-1:0] total
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned SUM_W = TOTAL_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    EMIT    = 3'd2,
    REJ     = 3'd3,
    RELEASE = 3'd4,
    LOCK    = 3'd5
  } state_t;

  logic sync_a1, sync_a, sync_b1, sync_b;
  logic [1:0] s;

  state_t             state, state_n;
  logic [1:0]         pat, pat_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [1:0]         coin_n;
  logic               reject_n;
  logic               busy_n;
  logic [TOTAL_W-1:0] total_n;

  logic [1:0]         inc;
  logic [SUM_W-1:0]   sum_ext;
  logic [TOTAL_W-1:0] total_sat;

  assign s = {sync_b, sync_a};

  // Two-flop synchronizers for the asynchronous sensor lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a1 <= 1'b0;
      sync_a  <= 1'b0;
      sync_b1 <= 1'b0;
      sync_b  <= 1'b0;
    end else begin
      sync_a1 <= sense_a;
      sync_a  <= sync_a1;
      sync_b1 <= sense_b;
      sync_b  <= sync_b1;
    end
  end

  // Saturating add of the qualified coin's value to the running total
  always_comb begin
    inc       = (pat == 2'b01) ? 2'd1 : 2'd2;
    sum_ext   = {1'b0, total} + SUM_W'(inc);
    total_sat = sum_ext[TOTAL_W] ? {TOTAL_W{1'b1}} : sum_ext[TOTAL_W-1:0];
  end

  // State and output registers; outputs load on the edge entering EMIT/REJ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pat    <= 2'b00;
      cnt    <= '0;
      gap    <= '0;
      coin   <= 2'b00;
      reject <= 1'b0;
      busy   <= 1'b0;
      total  <= '0;
    end else begin
      state  <= state_n;
      pat    <= pat_n;
      cnt    <= cnt_n;
      gap    <= gap_n;
      coin   <= coin_n;
      reject <= reject_n;
      busy   <= busy_n;
      total  <= total_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    pat_n    = pat;
    cnt_n    = cnt;
    gap_n    = gap;
    coin_n   = 2'b00;
    reject_n = 1'b0;
    total_n  = total;

    case (state)
      IDLE: begin
        if (s != 2'b00) begin
          pat_n   = s;
          cnt_n   = CNT_W'(1);
          state_n = QUAL;
        end
      end
      QUAL: begin
        if (s != pat) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          if (pat == 2'b11 || !accept_en) begin
            state_n  = REJ;
            reject_n = 1'b1;
          end else begin
            state_n = EMIT;
            coin_n  = pat;
            total_n = total_sat;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      EMIT, REJ: begin
        state_n = RELEASE;
      end
      RELEASE: begin
        // one output per insertion: wait for the sensors to clear
        if (s == 2'b00) begin
          gap_n   = GAP_LOAD;
          state_n = LOCK;
        end
      end
      LOCK: begin
        if (gap <= GAP_W'(1)) begin
          gap_n   = '0;
          state_n = IDLE;
        end else begin
          gap_n = gap - GAP_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
